// File: rtl/uart_tx.sv
//==============================================================================
// uart_tx: LSB-first UART transmitter with a one-byte holding register; optional parity via UART_TX_PARITY_EN.
// Revision 1.0
//==============================================================================
`default_nettype none

module uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_W - 1);
  localparam logic              c_stop_last = 1'(STOP_BITS - 1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_parity = 3'd3;
`endif
  localparam logic [2:0] c_stop   = 3'd4;

  if (CLKS_PER_BIT < 1 || DATA_W < 1 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_tx: illegal parameter set");
  end

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              stop_q, stop_d;
  logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic w_accept;
  logic w_baud_end;

  assign w_accept   = in_valid && !hold_full_q;
  assign w_baud_end = (baud_q == c_baud_last);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    tx_d        = tx_q;
    baud_d      = (state_q == c_idle || w_baud_end) ? '0 : baud_q + BAUD_W'(1);
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    if (w_accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    // Loading the holding register always starts a frame; shared by IDLE and STOP.
    if ((state_q == c_idle && hold_full_q) ||
        (state_q == c_stop && w_baud_end && stop_q == c_stop_last && hold_full_q)) begin
      state_d     = c_start;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d       = (^hold_q) ^ 1'(PARITY_ODD);
`endif
    end else begin
      case (state_q)
        c_idle: begin
          tx_d = 1'b1;
        end
        c_start: begin
          if (w_baud_end) begin
            state_d = c_data;
            tx_d    = shift_q[0];
            bit_d   = '0;
          end
        end
        c_data: begin
          if (w_baud_end) begin
            if (bit_q == c_bit_last) begin
`ifdef UART_TX_PARITY_EN
              state_d = c_parity;
              tx_d    = par_q;
`else
              state_d = c_stop;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
`endif
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = shift_q >> 1;
              tx_d    = shift_d[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        c_parity: begin
          if (w_baud_end) begin
            state_d = c_stop;
            tx_d    = 1'b1;
            stop_d  = 1'b0;
          end
        end
`endif
        c_stop: begin
          if (w_baud_end) begin
            if (stop_q == c_stop_last) begin
              state_d = c_idle;
            end else begin
              stop_d = stop_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = c_idle;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= c_idle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      baud_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign in_ready = !hold_full_q;
  assign tx       = tx_q;
  assign busy     = (state_q != c_idle) | hold_full_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//==============================================================================
// tb_uart_tx: directed-vector bench for uart_tx (default, slow/2-stop and odd-parity instances).
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L  = 10 + P;
  localparam int L4 = 4 * (11 + P);

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] a_data,  b_data,  o_data;
  logic       a_valid, b_valid, o_valid;
  logic       a_ready, b_ready, o_ready;
  logic       a_tx,    b_tx,    o_tx;
  logic       a_busy,  b_busy,  o_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .tx(a_tx), .busy(a_busy)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .tx(b_tx), .busy(b_busy)
  );

  uart_tx #(.PARITY_ODD(1)) u_dut_o (
    .clk(clk), .rst_n(rst_n), .in_data(o_data), .in_valid(o_valid),
    .in_ready(o_ready), .tx(o_tx), .busy(o_busy)
  );

  // Expected line levels, index 0 = start bit; everything past the frame is idle/stop high.
  function automatic logic [15:0] frame(input logic [7:0] d, input logic odd);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[k];
    if (P == 1) f[9] = (^d) ^ odd;
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; o_valid = 1'b0;
    a_data = '0; b_data = '0; o_data = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({a_tx, a_busy, a_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL reset_hold: tx/busy/ready=%b expected 101", {a_tx, a_busy, a_ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({a_tx, a_busy, a_ready, b_tx, b_busy, b_ready} !== 6'b101101) begin
        miscompares++;
        $display("FAIL idle[%0d]: a/b tx,busy,ready=%b expected 101101", i,
                 {a_tx, a_busy, a_ready, b_tx, b_busy, b_ready});
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] exp_f;
    exp_f = frame(8'hAA, 1'b0);
    @(negedge clk);
    a_data = 8'hAA; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    vectors++;
    if ({a_tx, a_busy, a_ready} !== 3'b110) begin
      miscompares++;
      $display("FAIL single_accept: tx/busy/ready=%b expected 110", {a_tx, a_busy, a_ready});
    end
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      vectors++;
      if (a_tx !== exp_f[i] || a_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL single_bit[%0d]: tx=%b busy=%b expected tx=%b busy=1", i, a_tx, a_busy, exp_f[i]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({a_tx, a_busy, a_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL single_end: tx/busy/ready=%b expected 101", {a_tx, a_busy, a_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_f;
    logic        exp_rdy;
    exp_f = {frame(8'h2D, 1'b0), frame(8'hAA, 1'b0)};
    exp_f = exp_f >> 0;
    // Second frame follows at bit index L, not 16.
    exp_f = 32'(frame(8'hAA, 1'b0) & 16'((1 << L) - 1)) | (32'(frame(8'h2D, 1'b0)) << L);
    @(negedge clk);
    a_data = 8'hAA; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 2 * L; i++) begin
      @(negedge clk);
      exp_rdy = (i == 0) || (i >= L);
      vectors++;
      if (a_tx !== exp_f[i] || a_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL b2b_bit[%0d]: tx=%b ready=%b expected tx=%b ready=%b", i, a_tx, a_ready, exp_f[i], exp_rdy);
      end
      if (i == 0) begin
        a_data = 8'h2D; a_valid = 1'b1;
      end else if (i == 1) begin
        a_valid = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if ({a_tx, a_busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_end: tx/busy=%b expected 10", {a_tx, a_busy});
    end
  endtask

  task automatic test_slow_two_stop();
    logic [15:0] exp_f;
    exp_f = frame(8'h01, 1'b0);
    @(negedge clk);
    b_data = 8'h01; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < L4; i++) begin
      @(negedge clk);
      vectors++;
      if (b_tx !== exp_f[i/4] || b_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL slow_cyc[%0d]: tx=%b busy=%b expected tx=%b busy=1", i, b_tx, b_busy, exp_f[i/4]);
      end
    end
    @(negedge clk);
    vectors++;
    if ({b_tx, b_busy, b_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL slow_end: tx/busy/ready=%b expected 101", {b_tx, b_busy, b_ready});
    end
  endtask

  task automatic test_parity();
    logic [7:0] vec_d   [3];
    logic       vec_odd [3];
    logic       vec_par [3];
    logic [15:0] exp_f;
    logic        t;
    vec_d[0] = 8'h2D; vec_odd[0] = 1'b0; vec_par[0] = 1'b0;
    vec_d[1] = 8'h07; vec_odd[1] = 1'b0; vec_par[1] = 1'b1;
    vec_d[2] = 8'h2D; vec_odd[2] = 1'b1; vec_par[2] = 1'b1;
    for (int v = 0; v < 3; v++) begin
      exp_f = frame(vec_d[v], vec_odd[v]);
      @(negedge clk);
      if (vec_odd[v]) begin o_data = vec_d[v]; o_valid = 1'b1; end
      else            begin a_data = vec_d[v]; a_valid = 1'b1; end
      @(negedge clk);
      a_valid = 1'b0; o_valid = 1'b0;
      for (int i = 0; i < L + 1; i++) begin
        @(negedge clk);
        t = vec_odd[v] ? o_tx : a_tx;
        vectors++;
        if (t !== exp_f[i]) begin
          miscompares++;
          $display("FAIL parity_frame[%0d][%0d]: tx=%b expected %b", v, i, t, exp_f[i]);
        end
        if (i == 9) begin
          vectors++;
          if (t !== vec_par[v]) begin
            miscompares++;
            $display("FAIL parity_bit[%0d]: tx=%b expected %b", v, t, vec_par[v]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    a_data = 8'h00; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a_data = 8'h55; a_valid = 1'b1;
      end else if (i == 1) begin
        a_valid = 1'b0;
      end
    end
    vectors++;
    if ({a_tx, a_ready, a_busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL midframe_pre: tx/ready/busy=%b expected 001", {a_tx, a_ready, a_busy});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_tx, a_busy, a_ready} !== 3'b101) begin
      miscompares++;
      $display("FAIL midframe_async: tx/busy/ready=%b expected 101", {a_tx, a_busy, a_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      vectors++;
      if ({a_tx, a_busy, a_ready} !== 3'b101) begin
        miscompares++;
        $display("FAIL midframe_after[%0d]: tx/busy/ready=%b expected 101", i, {a_tx, a_busy, a_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_two_stop();
    if (P == 1) test_parity();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
